// File: rtl/approx_mult_pkg.sv
// Shared types and width helpers for the leading-one-normalising approximate multiplier.
package approx_mult_pkg;

  typedef enum logic [2:0] {IDLE, NORM, MULT, DENORM, DONE} state_t;

  // Width of a normalisation count (0..W-K); never narrower than one bit.
  function automatic int sw_width(input int w, input int k);
    int n;
    n = $clog2(w - k + 1);
    return (n < 1) ? 1 : n;
  endfunction

  // Width of the exponent counter (0..2(W-K)); never narrower than one bit.
  function automatic int ew_width(input int w, input int k);
    int n;
    n = $clog2(2 * (w - k) + 1);
    return (n < 1) ? 1 : n;
  endfunction

  // Round-half-up of a k-bit truncated value, saturating at 2^k-1.
  function automatic logic [31:0] round_sat(input logic [31:0] t, input logic rb, input int k);
    logic [32:0] max_v;
    max_v = (33'd1 << k) - 33'd1;
    if (rb && ({1'b0, t} != max_v))
      return t + 32'd1;
    return t;
  endfunction

endpackage

// File: rtl/approx_mult_seq_if.sv
// Operand/result handshake bundle between producer, multiplier and accumulator.
interface approx_mult_seq_if
  import approx_mult_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int K     = 8
);
  localparam int SW = sw_width(WIDTH, K);

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in1;
  logic [WIDTH-1:0]     in2;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   result;
  logic [SW-1:0]        shift_a;
  logic [SW-1:0]        shift_b;

  modport slave (
    input  in_valid, in1, in2, out_ready,
    output in_ready, out_valid, result, shift_a, shift_b
  );

  modport master (
    output in_valid, in1, in2, out_ready,
    input  in_ready, out_valid, result, shift_a, shift_b
  );
endinterface

// File: rtl/approx_mult_seq_norm_shifter.sv
// One-bit-per-cycle left normaliser: shifts until the MSB is set or the shift cap is reached.
module norm_shifter #(
  parameter int WIDTH = 16,
  parameter int MAXSH = 8,
  parameter int CW    = (MAXSH > 0) ? $clog2(MAXSH + 1) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             done
);

  assign done = dout[WIDTH-1] || (count == CW'(MAXSH));

  always_ff @(posedge clk) begin
    if (rst) begin
      dout  <= '0;
      count <= '0;
    end else if (load) begin
      dout  <= din;
      count <= '0;
    end else if (en && !done) begin
      dout  <= dout << 1;
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/approx_mult_seq.sv
// Sequential approximate multiplier: normalise both operands, multiply the top K bits,
// then shift the product back to full scale one bit per cycle.
module approx_mult_seq
  import approx_mult_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int K     = 8,
  parameter int ROUND = 0
) (
  input  logic             clk,
  input  logic             rst,
  approx_mult_seq_if.slave bus
);

  localparam int MAXSH = WIDTH - K;
  localparam int SW    = sw_width(WIDTH, K);
  localparam int EW    = ew_width(WIDTH, K);
  localparam int RW    = 2 * WIDTH;

  state_t            state;
  logic              in_ready_r;
  logic              out_valid_r;
  logic [RW-1:0]     result_r;
  logic [SW-1:0]     shift_a_r;
  logic [SW-1:0]     shift_b_r;
  logic [EW-1:0]     exp_cnt;
  logic [EW-1:0]     exp_init;

  logic [WIDTH-1:0]  a_n;
  logic [WIDTH-1:0]  b_n;
  logic [SW-1:0]     cnt_a;
  logic [SW-1:0]     cnt_b;
  logic              done_a;
  logic              done_b;
  logic              load;
  logic              norm_en;
  logic              a_rb;
  logic              b_rb;
  logic [K-1:0]      a_t;
  logic [K-1:0]      b_t;
  logic [2*K-1:0]    prod;

  assign load    = (state == IDLE) && bus.in_valid;
  assign norm_en = (state == NORM);

  norm_shifter #(.WIDTH(WIDTH), .MAXSH(MAXSH), .CW(SW)) u_norm_a (
    .clk(clk), .rst(rst), .load(load), .en(norm_en),
    .din(bus.in1), .dout(a_n), .count(cnt_a), .done(done_a)
  );

  norm_shifter #(.WIDTH(WIDTH), .MAXSH(MAXSH), .CW(SW)) u_norm_b (
    .clk(clk), .rst(rst), .load(load), .en(norm_en),
    .din(bus.in2), .dout(b_n), .count(cnt_b), .done(done_b)
  );

  // The round bit is the first discarded bit; with K==W nothing is discarded.
  if (ROUND != 0 && K < WIDTH) begin : g_round
    assign a_rb = a_n[WIDTH-K-1];
    assign b_rb = b_n[WIDTH-K-1];
  end else begin : g_trunc
    assign a_rb = 1'b0;
    assign b_rb = 1'b0;
  end

  assign a_t      = K'(round_sat(32'(a_n[WIDTH-1 -: K]), a_rb, K));
  assign b_t      = K'(round_sat(32'(b_n[WIDTH-1 -: K]), b_rb, K));
  assign prod     = (2*K)'(a_t) * (2*K)'(b_t);
  assign exp_init = EW'(2 * MAXSH - int'(cnt_a) - int'(cnt_b));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      result_r    <= '0;
      shift_a_r   <= '0;
      shift_b_r   <= '0;
      exp_cnt     <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          state      <= NORM;
          in_ready_r <= 1'b0;
        end
        NORM: if (done_a && done_b) state <= MULT;
        MULT: begin
          result_r  <= RW'(prod);
          exp_cnt   <= exp_init;
          shift_a_r <= cnt_a;
          shift_b_r <= cnt_b;
          if (exp_init == '0) begin
            state       <= DONE;
            out_valid_r <= 1'b1;
          end else begin
            state <= DENORM;
          end
        end
        DENORM: begin
          result_r <= result_r << 1;
          exp_cnt  <= exp_cnt - EW'(1);
          if (exp_cnt == EW'(1)) begin
            state       <= DONE;
            out_valid_r <= 1'b1;
          end
        end
        DONE: if (bus.out_ready) begin
          state       <= IDLE;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.result    = result_r;
  assign bus.shift_a   = shift_a_r;
  assign bus.shift_b   = shift_b_r;

endmodule

// File: tb/tb_approx_mult_seq.sv
// Bench for approx_mult_seq: truncating and rounding instances driven in lock-step.
module tb_approx_mult_seq;
  localparam int W     = 16;
  localparam int K     = 8;
  localparam int MAXSH = W - K;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] in1 = '0;
  logic [15:0] in2 = '0;

  always #5 clk = ~clk;

  approx_mult_seq_if #(.WIDTH(W), .K(K)) bus0 ();
  approx_mult_seq_if #(.WIDTH(W), .K(K)) bus1 ();

  assign bus0.in_valid  = in_valid;
  assign bus0.in1       = in1;
  assign bus0.in2       = in2;
  assign bus0.out_ready = out_ready;
  assign bus1.in_valid  = in_valid;
  assign bus1.in1       = in1;
  assign bus1.in2       = in2;
  assign bus1.out_ready = out_ready;

  approx_mult_seq #(.WIDTH(W), .K(K), .ROUND(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  approx_mult_seq #(.WIDTH(W), .K(K), .ROUND(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] r_trunc;
    logic [31:0] r_round;
    int          sa;
    int          sb;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: leading-zero count capped at W-K, keep top K bits, scale back by 2^e.
  function automatic int lead_zeros(input logic [15:0] v);
    for (int i = 0; i < MAXSH; i++)
      if (v[15-i]) return i;
    return MAXSH;
  endfunction

  function automatic longint top_bits(input logic [15:0] v, input int s, input bit rnd);
    logic [15:0] n;
    longint      t;
    n = v << s;
    t = longint'(n >> (W - K));
    if (rnd && n[W-K-1] && t != (64'd1 << K) - 1) t = t + 1;
    return t;
  endfunction

  task automatic model(input logic [15:0] a, input logic [15:0] b, input bit rnd,
                       output logic [31:0] r, output int sa, output int sb, output int lat);
    int e;
    sa  = lead_zeros(a);
    sb  = lead_zeros(b);
    e   = 2 * MAXSH - sa - sb;
    r   = 32'((top_bits(a, sa, rnd) * top_bits(b, sb, rnd)) << e);
    lat = ((sa > sb) ? sa : sb) + e + 2;
  endtask

  // One transaction; optionally hold out_ready low for `hold` cycles while poking in_valid.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] er0, input logic [31:0] er1,
                        input int esa, input int esb, input int elat, input int hold);
    int lat;
    check({tag, "/in_ready_idle"}, 64'(bus0.in_ready), 64'd1);
    in1 = a; in2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in1 = 16'($urandom); in2 = 16'($urandom);
    lat = 0;
    while (!bus0.out_valid && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "/latency"}, 64'(lat), 64'(elat));
    check({tag, "/result_trunc"}, 64'(bus0.result), 64'(er0));
    check({tag, "/result_round"}, 64'(bus1.result), 64'(er1));
    check({tag, "/shift_a"}, 64'(bus0.shift_a), 64'(esa));
    check({tag, "/shift_b"}, 64'(bus0.shift_b), 64'(esb));
    check({tag, "/valid_round"}, 64'(bus1.out_valid), 64'd1);
    check({tag, "/in_ready_busy"}, 64'(bus0.in_ready), 64'd0);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; in1 = 16'($urandom); in2 = 16'($urandom);
      @(posedge clk); #1;
      check({tag, "/hold_result"}, 64'(bus0.result), 64'(er0));
      check({tag, "/hold_valid"}, 64'(bus0.out_valid), 64'd1);
      check({tag, "/hold_in_ready"}, 64'(bus0.in_ready), 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "/valid_drop"}, 64'(bus0.out_valid), 64'd0);
    check({tag, "/back_idle"}, 64'(bus0.in_ready), 64'd1);
  endtask

  task automatic reset_mid(input string tag, input logic [15:0] a, input logic [15:0] b, input int delay);
    bit seen;
    in1 = a; in2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (delay) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check({tag, "/rst_valid"}, 64'(bus0.out_valid), 64'd0);
    check({tag, "/rst_result"}, 64'(bus0.result | bus1.result), 64'd0);
    check({tag, "/rst_in_ready"}, 64'(bus0.in_ready), 64'd1);
    check({tag, "/rst_shift"}, 64'({bus0.shift_a, bus0.shift_b}), 64'd0);
    seen = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (bus0.out_valid || bus1.out_valid) seen = 1'b1;
    end
    check({tag, "/no_stale_valid"}, 64'(seen), 64'd0);
  endtask

  vec_t vecs[6];

  initial begin
    logic [31:0] r0, r1;
    int          sa, sb, lat;
    logic [15:0] a, b;

    vecs[0] = '{16'h00F3, 16'h0102, 32'h0000F4E6, 32'h0000F4E6, 8, 7, 11};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFE010000, 32'hFE010000, 0, 0, 18};
    vecs[2] = '{16'h0000, 16'h1234, 32'h0,        32'h0,        8, 3, 15};
    vecs[3] = '{16'h0003, 16'h0005, 32'd15,       32'd15,       8, 8, 10};
    vecs[4] = '{16'h1234, 16'h0100, 32'h00122000, 32'h00124000, 3, 7, 15};
    vecs[5] = '{16'h8000, 16'h0001, 32'h00008000, 32'h00008000, 0, 8, 18};

    repeat (3) @(posedge clk);
    #1;
    check("reset/in_ready", 64'(bus0.in_ready), 64'd1);
    check("reset/out_valid", 64'(bus0.out_valid), 64'd0);
    check("reset/result", 64'(bus0.result), 64'd0);
    check("reset/shifts", 64'({bus0.shift_a, bus0.shift_b}), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].r_trunc, vecs[i].r_round,
             vecs[i].sa, vecs[i].sb, vecs[i].lat, 0);

    run_op("backpressure", vecs[0].a, vecs[0].b, vecs[0].r_trunc, vecs[0].r_round,
           vecs[0].sa, vecs[0].sb, vecs[0].lat, 5);
    run_op("after_bp", vecs[4].a, vecs[4].b, vecs[4].r_trunc, vecs[4].r_round,
           vecs[4].sa, vecs[4].sb, vecs[4].lat, 0);

    reset_mid("rst_norm", 16'h0003, 16'h0005, 2);
    run_op("post_rst_norm", vecs[0].a, vecs[0].b, vecs[0].r_trunc, vecs[0].r_round,
           vecs[0].sa, vecs[0].sb, vecs[0].lat, 0);
    reset_mid("rst_denorm", 16'hFFFF, 16'hFFFF, 4);
    run_op("post_rst_denorm", vecs[1].a, vecs[1].b, vecs[1].r_trunc, vecs[1].r_round,
           vecs[1].sa, vecs[1].sb, vecs[1].lat, 0);

    for (int n = 0; n < 40; n++) begin
      a = 16'($urandom & ((32'd1 << $urandom_range(0, 16)) - 1));
      b = 16'($urandom & ((32'd1 << $urandom_range(0, 16)) - 1));
      model(a, b, 1'b1, r1, sa, sb, lat);
      model(a, b, 1'b0, r0, sa, sb, lat);
      run_op($sformatf("rand%0d_%04h_%04h", n, a, b), a, b, r0, r1, sa, sb, lat, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
